// File: rtl/demux_1_to_4_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// demux_1_to_4_dispatch_pkg
//   Shared constants and types for the 1-to-N particle-record dispatcher.
//   - DEFAULT_DATA_WIDTH       : one record, three 32-bit position words
//   - DEFAULT_NUM_OUTPUT_PORTS : number of downstream consumers
//   - PORT_FIFO_DEPTH          : entries buffered per output port
//   - occ_e                    : per-port buffer occupancy encoding
//   - sel_width_for()          : select width for a given port count
// -----------------------------------------------------------------------------
package demux_1_to_4_dispatch_pkg;

   localparam int DEFAULT_DATA_WIDTH       = 3 * 32;
   localparam int DEFAULT_NUM_OUTPUT_PORTS = 4;
   localparam int PORT_FIFO_DEPTH          = 2;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   // ceil(log2(num_ports)), never narrower than one bit.
   function automatic int sel_width_for(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

endpackage

// File: rtl/demux_port_buffer.sv
// -----------------------------------------------------------------------------
// demux_port_buffer
//   Two-entry FIFO for one output port. Built as head/tail registers rather
//   than a pointer-addressed array so the head entry drives the port output
//   straight from a flop.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     push         : write push_data (ignored when full)
//     push_data    : record to enqueue
//     pop          : consumer accepts the head entry (ignored when empty)
//     head_data    : oldest entry, registered
//     occupancy    : current fill level (0..2)
//     valid        : occupancy != 0
//     empty_next   : buffer will be empty after this clock edge
// -----------------------------------------------------------------------------
module demux_port_buffer
   import demux_1_to_4_dispatch_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head_data,
   output occ_e                  occupancy,
   output logic                  valid,
   output logic                  empty_next
);

   occ_e                  occ_q, occ_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  push_ok;
   logic                  pop_ok;

   assign push_ok = push && (occ_q != OCC_FULL);
   assign pop_ok  = pop  && (occ_q != OCC_EMPTY);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      unique case (occ_q)
         OCC_EMPTY: begin
            if (push_ok) begin
               head_d = push_data;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            unique case ({push_ok, pop_ok})
               2'b10: begin
                  tail_d = push_data;
                  occ_d  = OCC_FULL;
               end
               2'b01: occ_d  = OCC_EMPTY;
               // Head leaves as the new record arrives: it becomes the head.
               2'b11: head_d = push_data;
               default: ;
            endcase
         end
         OCC_FULL: begin
            // Push is never accepted here, so a pop just shifts tail to head.
            if (pop_ok) begin
               head_d = tail_q;
               occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   // NOTE: data registers are reset as well, because the port output must read
   // zero while in reset; storage that never reaches an output need not be.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples its pre-edge inputs regardless of statement order.
         occ_q  <= OCC_EMPTY;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign head_data  = head_q;
   assign occupancy  = occ_q;
   assign valid      = (occ_q != OCC_EMPTY);
   assign empty_next = (occ_d == OCC_EMPTY);

endmodule

// File: rtl/demux_1_to_4_dispatch.sv
// -----------------------------------------------------------------------------
// demux_1_to_4_dispatch
//   Registered 1-to-N demultiplexer: routes each input record to the output
//   port named by in_sel, with a two-entry buffer per port so a stalled
//   consumer only blocks records aimed at it.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     in_valid    : input record present
//     in_ready    : record accepted this cycle (depends on in_sel and the
//                   selected port's occupancy only)
//     in_sel      : destination port index
//     in_data     : input record
//     out_valid   : per-port record present (bit p = port p)
//     out_ready   : per-port consumer accepts
//     out_data    : port p at [(p+1)*DATA_WIDTH-1 : p*DATA_WIDTH]
//     drop_pulse  : one-cycle pulse after an out-of-range record is discarded
//     idle        : all port buffers empty (registered)
// -----------------------------------------------------------------------------
module demux_1_to_4_dispatch
   import demux_1_to_4_dispatch_pkg::*;
#(
   parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
   parameter int NUM_OUTPUT_PORTS = DEFAULT_NUM_OUTPUT_PORTS,
   parameter int SEL_WIDTH        = sel_width_for(NUM_OUTPUT_PORTS)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [SEL_WIDTH-1:0]                   in_sel,
   input  logic [DATA_WIDTH-1:0]                  in_data,
   output logic [NUM_OUTPUT_PORTS-1:0]            out_valid,
   input  logic [NUM_OUTPUT_PORTS-1:0]            out_ready,
   output logic [NUM_OUTPUT_PORTS*DATA_WIDTH-1:0] out_data,
   output logic                                   drop_pulse,
   output logic                                   idle
);

   logic [NUM_OUTPUT_PORTS-1:0] sel_hit;
   logic [NUM_OUTPUT_PORTS-1:0] port_full;
   logic [NUM_OUTPUT_PORTS-1:0] port_push;
   logic [NUM_OUTPUT_PORTS-1:0] port_empty_next;
   occ_e                        port_occ [NUM_OUTPUT_PORTS];
   logic                        sel_in_range;
   logic                        in_fire;

   // One-hot decode of in_sel; an out-of-range select hits no port.
   always_comb begin
      sel_hit = '0;
      for (int p = 0; p < NUM_OUTPUT_PORTS; p++) begin
         sel_hit[p] = (in_sel == SEL_WIDTH'(p));
      end
   end

   assign sel_in_range = |sel_hit;

   // Only registered occupancy feeds in_ready, so out_ready never reaches it
   // combinationally. An out-of-range select is always accepted (and dropped).
   assign in_ready  = ~|(sel_hit & port_full);
   assign in_fire   = in_valid && in_ready;
   assign port_push = {NUM_OUTPUT_PORTS{in_fire}} & sel_hit;

   for (genvar g = 0; g < NUM_OUTPUT_PORTS; g++) begin : g_port
      demux_port_buffer #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_buf (
         .clk        (clk),
         .rst        (rst),
         .push       (port_push[g]),
         .push_data  (in_data),
         .pop        (out_ready[g]),
         .head_data  (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .occupancy  (port_occ[g]),
         .valid      (out_valid[g]),
         .empty_next (port_empty_next[g])
      );
      assign port_full[g] = (port_occ[g] == OCC_FULL);
   end

   // idle is built from each buffer's next-state emptiness so that the
   // registered flag changes on the same edge as out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_pulse <= 1'b0;
         idle       <= 1'b1;
      end else begin
         drop_pulse <= in_fire && !sel_in_range;
         idle       <= &port_empty_next;
      end
   end

endmodule
